// File: rtl/e_branch_resolve.sv
// Execute-stage branch/jump resolution: evaluates the condition, computes the target and
// issues a registered redirect + one-cycle flush to fetch, holding it until fetch accepts.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | evaluating EX instructions, no redirect outstanding
// REDIRECT | redirect presented to fetch; EX input is wrong-path and ignored
module e_branch_resolve #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_br_valid,
   input  logic [2:0]        i_br_bop,
   input  logic [1:0]        i_br_jump,
   input  logic [DATA_W-1:0] i_br_rs,
   input  logic [DATA_W-1:0] i_br_rt,
   input  logic [PC_W-1:0]   i_br_pc4,
   input  logic [15:0]       i_br_imm,
   input  logic [25:0]       i_br_jidx,
   input  logic              i_br_fetch_ready,
   output logic              o_br_redirect,
   output logic [PC_W-1:0]   o_br_target,
   output logic              o_br_flush,
   output logic              o_br_stall,
   output logic              o_br_misalign,
   output logic [CNT_W-1:0]  o_br_count,
   output logic [CNT_W-1:0]  o_br_taken_cnt
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   target_q;
   logic              misalign_q;
   logic              flush_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  taken_q;

   logic              is_jump;
   logic              is_branch;
   logic              cond;
   logic              taken;
   logic              rs_neg;
   logic              rs_zero;
   logic [PC_W-1:0]   target_c;
   logic              accept;
   logic              count_en;

   assign rs_neg  = i_br_rs[DATA_W-1];
   assign rs_zero = (i_br_rs == '0);

   // jump encoding 11 is not a jump and falls back to bop decoding
   always_comb begin
      is_jump   = (i_br_jump == 2'b01) || (i_br_jump == 2'b10);
      is_branch = 1'b0;
      cond      = 1'b0;
      if (!is_jump) begin
         case (i_br_bop)
            3'b001:  begin is_branch = 1'b1; cond = (i_br_rs == i_br_rt);  end
            3'b010:  begin is_branch = 1'b1; cond = (i_br_rs != i_br_rt);  end
            3'b011:  begin is_branch = 1'b1; cond = rs_neg | rs_zero;      end
            3'b100:  begin is_branch = 1'b1; cond = ~rs_neg & ~rs_zero;    end
            3'b101:  begin is_branch = 1'b1; cond = rs_neg;                end
            3'b110:  begin is_branch = 1'b1; cond = ~rs_neg;               end
            default: begin is_branch = 1'b0; cond = 1'b0;                  end
         endcase
      end
      taken = is_jump | (is_branch & cond);
   end

   always_comb begin
      target_c = i_br_pc4 + {{(PC_W-18){i_br_imm[15]}}, i_br_imm, 2'b00};
      if (i_br_jump == 2'b01) begin
         target_c = {i_br_pc4[PC_W-1:PC_W-4], i_br_jidx, 2'b00};
      end else if (i_br_jump == 2'b10) begin
         target_c = i_br_rs[PC_W-1:0];
      end
   end

   assign accept   = (state_q == IDLE) && i_br_valid && taken;
   assign count_en = (state_q == IDLE) && i_br_valid && (is_jump || is_branch);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = REDIRECT;
         REDIRECT: if (i_br_fetch_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         target_q   <= '0;
         misalign_q <= 1'b0;
         flush_q    <= 1'b0;
         count_q    <= '0;
         taken_q    <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= accept;
         if (accept) begin
            target_q   <= target_c;
            misalign_q <= (target_c[1:0] != 2'b00);
         end
         if (count_en && (count_q != {CNT_W{1'b1}})) count_q <= count_q + 1'b1;
         if (accept && (taken_q != {CNT_W{1'b1}})) taken_q <= taken_q + 1'b1;
      end
   end

   assign o_br_redirect  = (state_q == REDIRECT);
   assign o_br_target    = target_q;
   assign o_br_flush     = flush_q;
   assign o_br_stall     = o_br_redirect & ~i_br_fetch_ready;
   assign o_br_misalign  = misalign_q & o_br_redirect;
   assign o_br_count     = count_q;
   assign o_br_taken_cnt = taken_q;

endmodule

// File: tb/tb_e_branch_resolve.sv
// Bench for e_branch_resolve: behavioural model checked every cycle, plus directed
// vectors with literal expectations; a second instance with 4-bit counters covers saturation.
module tb_e_branch_resolve;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [2:0]  bop = '0;
   logic [1:0]  jump = '0;
   logic [31:0] rs = '0;
   logic [31:0] rt = '0;
   logic [31:0] pc4 = '0;
   logic [15:0] imm = '0;
   logic [25:0] jidx = '0;
   logic        ready = 1'b1;

   logic        redirect, flush, stall, misalign;
   logic [31:0] target;
   logic [15:0] count, tcount;
   logic        redirect4, flush4, stall4, misalign4;
   logic [31:0] target4;
   logic [3:0]  count4, tcount4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   e_branch_resolve #(.PC_W(32), .DATA_W(32), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_br_valid(valid), .i_br_bop(bop), .i_br_jump(jump),
      .i_br_rs(rs), .i_br_rt(rt), .i_br_pc4(pc4), .i_br_imm(imm), .i_br_jidx(jidx),
      .i_br_fetch_ready(ready), .o_br_redirect(redirect), .o_br_target(target),
      .o_br_flush(flush), .o_br_stall(stall), .o_br_misalign(misalign),
      .o_br_count(count), .o_br_taken_cnt(tcount)
   );

   e_branch_resolve #(.PC_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_br_valid(valid), .i_br_bop(bop), .i_br_jump(jump),
      .i_br_rs(rs), .i_br_rt(rt), .i_br_pc4(pc4), .i_br_imm(imm), .i_br_jidx(jidx),
      .i_br_fetch_ready(ready), .o_br_redirect(redirect4), .o_br_target(target4),
      .o_br_flush(flush4), .o_br_stall(stall4), .o_br_misalign(misalign4),
      .o_br_count(count4), .o_br_taken_cnt(tcount4)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_busy = 0, m_first = 0, m_mis = 0, started = 0;
   logic [31:0] m_tgt = '0;
   int          m_cnt = 0, m_tcnt = 0;

   function automatic bit m_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = signed'(a);
      case (op)
         3'd1: return a == b;
         3'd2: return a != b;
         3'd3: return sa <= 0;
         3'd4: return sa > 0;
         3'd5: return sa < 0;
         3'd6: return sa >= 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_target(input logic [1:0] jp, input logic [31:0] a,
                                           input logic [31:0] p, input logic [15:0] im,
                                           input logic [25:0] ix);
      int off;
      if (jp == 2'd1) return (p & 32'hF000_0000) | (32'(ix) * 4);
      if (jp == 2'd2) return a;
      off = int'(signed'(im)) * 4;
      return p + 32'(off);
   endfunction

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clk) begin
      bit jj, br;
      started = 1;
      if (rst) begin
         m_busy = 0; m_first = 0; m_mis = 0; m_tgt = '0; m_cnt = 0; m_tcnt = 0;
      end else if (m_busy) begin
         m_first = 0;
         if (ready) m_busy = 0;
      end else if (valid) begin
         jj = (jump == 2'd1) || (jump == 2'd2);
         br = !jj && (bop >= 3'd1) && (bop <= 3'd6);
         if (jj || br) m_cnt++;
         if (jj || (br && m_cond(bop, rs, rt))) begin
            m_tcnt++;
            m_busy  = 1;
            m_first = 1;
            m_tgt   = m_target(jump, rs, pc4, imm, jidx);
            m_mis   = (m_tgt[1:0] != 2'b00);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("redirect", redirect, m_busy);
         chk("flush", flush, m_busy && m_first);
         chk("stall", stall, m_busy && !ready);
         chk("misalign", misalign, m_busy && m_mis);
         if (m_busy) chk("target", target, m_tgt);
         chk("count", count, sat(m_cnt, 16));
         chk("taken_cnt", tcount, sat(m_tcnt, 16));
         chk("count4", count4, sat(m_cnt, 4));
         chk("taken_cnt4", tcount4, sat(m_tcnt, 4));
         chk("redirect4", redirect4, m_busy);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] b, input logic [1:0] j, input logic [31:0] a,
                        input logic [31:0] c, input logic [31:0] p, input logic [15:0] im,
                        input logic [25:0] ix);
      bop = b; jump = j; rs = a; rt = c; pc4 = p; imm = im; jidx = ix;
      valid = 1'b1;
      cyc();
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (redirect === 1'b1 && n < 10) begin
         cyc();
         n++;
      end
      if (redirect !== 1'b0) chk("wait_idle_timeout", redirect, 1'b0);
   endtask

   typedef struct {
      logic [2:0]  b;
      logic [31:0] a;
      logic [31:0] c;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{3'd3, 32'h0000_0000, 32'h0};
      vecs[1] = '{3'd3, 32'h0000_0001, 32'h0};
      vecs[2] = '{3'd6, 32'hFFFF_FFFF, 32'h0};
      vecs[3] = '{3'd6, 32'h0000_0000, 32'h0};
      vecs[4] = '{3'd2, 32'h0000_0003, 32'h3};
      vecs[5] = '{3'd4, 32'h7FFF_FFFF, 32'h0};

      cyc(); cyc();
      chk("rst_redirect", redirect, 1'b0);
      chk("rst_count", count, 16'd0);
      rst = 1'b0;

      issue(3'd1, 2'd0, 32'd5, 32'd5, 32'h100, 16'h0004, 26'd0);
      chk("beq_redirect", redirect, 1'b1);
      chk("beq_target", target, 32'h110);
      chk("beq_flush", flush, 1'b1);
      cyc();
      chk("beq_done", redirect, 1'b0);
      chk("beq_flush_off", flush, 1'b0);

      issue(3'd4, 2'd0, 32'd0, 32'd0, 32'h100, 16'h0004, 26'd0);
      chk("bgtz_nt_redirect", redirect, 1'b0);
      chk("bgtz_nt_count", count, 16'd2);
      chk("bgtz_nt_taken", tcount, 16'd1);

      issue(3'd5, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'h200, 16'h0000, 26'd0);
      chk("bltz_redirect", redirect, 1'b1);
      chk("bltz_target", target, 32'h200);
      cyc();

      issue(3'd1, 2'd0, 32'd9, 32'd9, 32'h100, 16'hFFFF, 26'd0);
      chk("beq_back_target", target, 32'hFC);
      cyc();

      issue(3'd0, 2'd1, 32'd0, 32'd0, 32'h4000_0004, 16'h0, 26'h10);
      chk("j_target", target, 32'h4000_0040);
      cyc();

      issue(3'd0, 2'd2, 32'h0040_0002, 32'd0, 32'h0, 16'h0, 26'h0);
      chk("jr_target", target, 32'h0040_0002);
      chk("jr_misalign", misalign, 1'b1);
      cyc();
      chk("after_jr_count", count, 16'd6);
      chk("after_jr_taken", tcount, 16'd5);

      foreach (vecs[i]) begin
         issue(vecs[i].b, 2'd0, vecs[i].a, vecs[i].c, 32'h800, 16'h0002, 26'd0);
         wait_idle();
      end
      chk("cond_table_count", count, 16'd12);
      chk("cond_table_taken", tcount, 16'd8);

      issue(3'd0, 2'd0, 32'd1, 32'd1, 32'h0, 16'h0, 26'd0);
      issue(3'd7, 2'd0, 32'd1, 32'd1, 32'h0, 16'h0, 26'd0);
      issue(3'd0, 2'd3, 32'd1, 32'd1, 32'h0, 16'h0, 26'd0);
      chk("nonbranch_count", count, 16'd12);
      issue(3'd1, 2'd3, 32'd4, 32'd4, 32'h1000, 16'h0001, 26'd0);
      chk("jump11_target", target, 32'h1004);
      wait_idle();
      issue(3'd2, 2'd1, 32'd4, 32'd4, 32'h0, 16'h0001, 26'h3FF_FFFF);
      chk("jump_priority_target", target, 32'h0FFF_FFFC);
      wait_idle();

      ready = 1'b0;
      issue(3'd1, 2'd0, 32'd7, 32'd7, 32'h300, 16'h0002, 26'd0);
      bop = 3'd2; jump = 2'd0; rs = 32'd1; rt = 32'd2; pc4 = 32'h500; imm = 16'h0010;
      valid = 1'b1;
      chk("hold1_stall", stall, 1'b1);
      chk("hold1_flush", flush, 1'b1);
      chk("hold1_target", target, 32'h308);
      cyc();
      chk("hold2_stall", stall, 1'b1);
      chk("hold2_flush", flush, 1'b0);
      cyc();
      chk("hold3_target", target, 32'h308);
      cyc();
      chk("hold4_redirect", redirect, 1'b1);
      ready = 1'b1;
      #1;
      chk("hold4_stall_release", stall, 1'b0);
      cyc();
      chk("released_redirect", redirect, 1'b0);
      chk("hold_count", count, 16'd15);
      cyc();
      valid = 1'b0;
      chk("b2b_redirect", redirect, 1'b1);
      chk("b2b_flush", flush, 1'b1);
      chk("b2b_target", target, 32'h540);
      cyc();

      ready = 1'b0;
      issue(3'd0, 2'd1, 32'd0, 32'd0, 32'h0, 16'h0, 26'd5);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_redirect", redirect, 1'b0);
      chk("midrst_stall", stall, 1'b0);
      chk("midrst_flush", flush, 1'b0);
      chk("midrst_target", target, 32'h0);
      chk("midrst_count", count, 16'd0);
      chk("midrst_taken", tcount, 16'd0);
      ready = 1'b1;

      for (int k = 0; k < 20; k++) begin
         issue(3'd0, 2'd1, 32'd0, 32'd0, 32'h0, 16'h0, 26'(k));
         cyc();
      end
      chk("sat4_count", count4, 4'd15);
      chk("sat4_taken", tcount4, 4'd15);
      chk("sat16_count", count, 16'd20);
      chk("sat16_taken", tcount, 16'd20);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
